// File: rtl/stack.sv
`default_nettype none
// ============================================================================
// Module   : stack
// Purpose  : Shift-register LIFO stack of DEPTH words. entry[0] is the top
//            and entry[1] the word below it; both are exposed directly as
//            registered outputs. Supports load (overwrite top), push, pop and
//            push+pop (replace top). No overflow/underflow tracking: pushes
//            on a full stack drop the bottom word, pops on an empty stack
//            shift in zeros.
// Revision : 1.0 - initial release
// ============================================================================
module stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8    // must be at least 2 so qnext has a backing entry
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] qtop,
  output logic [WIDTH-1:0] qnext
);

  logic [WIDTH-1:0] entry_q [DEPTH];
  logic [WIDTH-1:0] entry_d [DEPTH];

  // Next-state for every entry; priority load > push+pop > push > pop > hold.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
    end
    if (load) begin
      entry_d[0] = d;
    end else if (push && pop) begin
      // Simultaneous push and pop collapses to replacing the top word.
      entry_d[0] = d;
    end else if (push) begin
      for (int i = 1; i < DEPTH; i++) begin
        entry_d[i] = entry_q[i-1];
      end
      entry_d[0] = d;
    end else if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        entry_d[i] = entry_q[i+1];
      end
      entry_d[DEPTH-1] = '0;
    end
  end

  // Entry registers; synchronous reset clears the whole stack and overrides any command.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  assign qtop  = entry_q[0];
  assign qnext = entry_q[1];

endmodule
`default_nettype wire

// File: tb/tb_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack
// Purpose  : Scoreboard bench for stack. The stimulus process pushes the
//            hand-computed qtop/qnext for each command into a queue after the
//            sampling edge; a monitor pops and compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] nxt;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             load = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] d = '0;
  logic [WIDTH-1:0] qtop;
  logic [WIDTH-1:0] qnext;

  exp_t q_exp[$];
  int   checks = 0;
  int   failures = 0;

  stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .push  (push),
    .pop   (pop),
    .d     (d),
    .qtop  (qtop),
    .qnext (qnext)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are registered, so compare away from the rising edge.
  always @(negedge clk) begin
    if (q_exp.size() != 0) begin
      exp_t e;
      e = q_exp.pop_front();
      checks++;
      if (qtop !== e.top || qnext !== e.nxt) begin
        failures++;
        $display("FAIL %s: got qtop=%h qnext=%h, expected qtop=%h qnext=%h",
                 e.name, qtop, qnext, e.top, e.nxt);
      end
    end
  end

  // Apply one command for one rising edge; optionally queue the expected result.
  task automatic step(input string name, input logic r, input logic l,
                      input logic pu, input logic po, input logic [WIDTH-1:0] dv,
                      input bit chk, input logic [WIDTH-1:0] et,
                      input logic [WIDTH-1:0] en);
    exp_t e;
    @(negedge clk);
    reset = r; load = l; push = pu; pop = po; d = dv;
    @(posedge clk);
    if (chk) begin
      e.name = name; e.top = et; e.nxt = en;
      q_exp.push_back(e);
    end
  endtask

  initial begin
    // Arbitrary pre-reset pushes; contents undefined so nothing is checked.
    step("pre_push0", 0, 0, 1, 0, 16'h5A5A, 0, '0, '0);
    step("pre_push1", 0, 0, 1, 0, 16'hA5A5, 0, '0, '0);
    step("reset",     1, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000);

    // Push three, then pop past empty.
    step("push_aaaa", 0, 0, 1, 0, 16'hAAAA, 1, 16'hAAAA, 16'h0000);
    step("push_bbbb", 0, 0, 1, 0, 16'hBBBB, 1, 16'hBBBB, 16'hAAAA);
    step("push_cccc", 0, 0, 1, 0, 16'hCCCC, 1, 16'hCCCC, 16'hBBBB);
    step("hold",      0, 0, 0, 0, 16'hFFFF, 1, 16'hCCCC, 16'hBBBB);
    step("pop1",      0, 0, 0, 1, 16'h0000, 1, 16'hBBBB, 16'hAAAA);
    step("pop2",      0, 0, 0, 1, 16'h0000, 1, 16'hAAAA, 16'h0000);
    step("pop3",      0, 0, 0, 1, 16'h0000, 1, 16'h0000, 16'h0000);
    step("pop_empty", 0, 0, 0, 1, 16'h0000, 1, 16'h0000, 16'h0000);
    step("push_dddd", 0, 0, 1, 0, 16'hDDDD, 1, 16'hDDDD, 16'h0000);
    step("push_eeee", 0, 0, 1, 0, 16'hEEEE, 1, 16'hEEEE, 16'hDDDD);

    // Overflow: nine pushes into eight entries, then eight pops.
    step("ovf_reset", 1, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000);
    for (int k = 1; k <= 9; k++) begin
      logic [WIDTH-1:0] v;
      logic [WIDTH-1:0] vn;
      v  = WIDTH'(k);
      vn = WIDTH'(k - 1);
      step("ovf_push", 0, 0, 1, 0, v, 1, v, vn);
    end
    // Remaining after overflow top-down: 9,8,7,6,5,4,3,2 (0001 dropped).
    for (int k = 1; k <= 8; k++) begin
      logic [WIDTH-1:0] et;
      logic [WIDTH-1:0] en;
      et = (k <= 7) ? WIDTH'(9 - k) : '0;
      en = (k <= 6) ? WIDTH'(8 - k) : '0;
      step("ovf_pop", 0, 0, 0, 1, 16'h0000, 1, et, en);
    end

    // Load and simultaneous commands on a 0002/0001 stack.
    step("push_0001",   0, 0, 1, 0, 16'h0001, 1, 16'h0001, 16'h0000);
    step("push_0002",   0, 0, 1, 0, 16'h0002, 1, 16'h0002, 16'h0001);
    step("load_00ff",   0, 1, 0, 0, 16'h00FF, 1, 16'h00FF, 16'h0001);
    step("pushpop_33",  0, 0, 1, 1, 16'h0033, 1, 16'h0033, 16'h0001);
    step("loadpush_44", 0, 1, 1, 0, 16'h0044, 1, 16'h0044, 16'h0001);
    step("loadpop_55",  0, 1, 0, 1, 16'h0055, 1, 16'h0055, 16'h0001);
    step("pop_after",   0, 0, 0, 1, 16'h0000, 1, 16'h0001, 16'h0000);

    // Reset beats a simultaneous push.
    step("push_7777",   0, 0, 1, 0, 16'h7777, 1, 16'h7777, 16'h0001);
    step("reset_push",  1, 0, 1, 0, 16'h1234, 1, 16'h0000, 16'h0000);
    step("hold_after",  0, 0, 0, 0, 16'h1234, 1, 16'h0000, 16'h0000);

    // Quiesce and let the monitor drain the scoreboard, bounded.
    @(negedge clk);
    reset = 0; load = 0; push = 0; pop = 0; d = '0;
    repeat (3) @(negedge clk);
    #1;
    if (q_exp.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected results never compared, required 0", q_exp.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stack.md
STACK -- requirements
Module: stack

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, meaning number of stack entries (minimum 2).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port load, input, 1 bit: overwrite the top entry with d.
REQ-006 SHALL have port push, input, 1 bit: push d onto the stack.
REQ-007 SHALL have port pop, input, 1 bit: remove the top entry.
REQ-008 SHALL have port d, input, WIDTH bits: write data for load and push.
REQ-009 SHALL have port qtop, output, WIDTH bits: current top entry, entry[0].
REQ-010 SHALL have port qnext, output, WIDTH bits: entry directly below the top, entry[1].

Function
REQ-011 SHALL store DEPTH entries entry[0..DEPTH-1] as a shift-register stack, with entry[0] as the top; all entries always hold defined values.
REQ-012 SHALL drive qtop and qnext directly from entry[0] and entry[1]; these are registered outputs with no combinational path from the inputs.
REQ-013 SHALL make each command's result visible on qtop/qnext immediately after the rising edge that samples the command (one-cycle latency).
REQ-014 Push: entry[0] <= d; entry[i] <= entry[i-1] for i = 1..DEPTH-1; the old entry[DEPTH-1] is discarded silently; push on a full stack is therefore legal.
REQ-015 Pop: entry[i] <= entry[i+1] for i = 0..DEPTH-2; entry[DEPTH-1] <= 0; pop on an empty stack is legal and yields zeros.
REQ-016 Load: entry[0] <= d; all other entries are unchanged.
REQ-017 SHALL apply command priority per edge as reset > load > (push and pop) > push > pop > hold.
REQ-018 SHALL treat push and pop asserted together, with load low, as a replace: entry[0] <= d, other entries unchanged.
REQ-019 SHALL hold all entries when no command is asserted.
REQ-020 SHALL execute a command held high for N edges N times; the command is level-sensitive and there is no edge detection.
REQ-021 SHALL have no overflow or underflow flags and no error state.

Reset
REQ-022 SHALL clear every entry to 0 on any rising edge where reset = 1, so qtop = 0 and qnext = 0 after that edge.
REQ-023 SHALL make reset override any simultaneous load, push or pop; a reset asserted mid-sequence discards all stack contents.
REQ-024 SHALL have no asynchronous behaviour; before the first reset edge, entry contents are undefined.

Verification
REQ-025 Reset scenario: assert reset for one edge after arbitrary pushes -> qtop = 0000, qnext = 0000.
REQ-026 Push scenario: after reset, push AAAA, BBBB, CCCC on one edge each -> qtop/qnext = CCCC/BBBB; then pop -> BBBB/AAAA; pop -> AAAA/0000; pop -> 0000/0000; pop again -> 0000/0000.
REQ-027 Push after empty-pops scenario: continuing from REQ-026, push DDDD then EEEE -> qtop/qnext = EEEE/DDDD.
REQ-028 Overflow scenario: push 0001..0009 (9 pushes, DEPTH = 8) then pop 8 times -> the 8th pop leaves qtop = 0000; 0001 is never seen.
REQ-029 Load and simultaneous-command scenario: with stack 0002/0001, load 00FF -> 00FF/0001; push + pop with d = 0033 -> 0033/0001; load + push with d = 0044 -> 0044/0001.
REQ-030 Reset-priority scenario: reset + push with d = 1234 on one edge -> 0000/0000.
